// File: rtl/fpnew_normalize_pipe.sv
// Two-stage FP normalizer: leading-zero count, normalizing/subnormal shift,
// round/sticky extraction and {exp, mantissa} packing for the rounder.
module fpnew_normalize_pipe #(
    parameter int unsigned EXP_BITS  = 8,
    parameter int unsigned MAN_BITS  = 23,
    parameter int unsigned IN_WIDTH  = 50,
    parameter int unsigned TAG_WIDTH = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [IN_WIDTH-1:0]          mant_i,
    input  logic [EXP_BITS+1:0]          exp_i,
    input  logic                         sign_i,
    input  logic [TAG_WIDTH-1:0]         tag_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [EXP_BITS+MAN_BITS-1:0] abs_value_o,
    output logic [1:0]                   round_sticky_o,
    output logic                         sign_o,
    output logic [TAG_WIDTH-1:0]         tag_o,
    output logic                         zero_o,
    output logic                         overflow_o
);

    localparam int unsigned W   = IN_WIDTH;
    localparam int unsigned EW  = EXP_BITS + 2;
    localparam int unsigned LZW = $clog2(IN_WIDTH + 1);
    localparam int unsigned AW  = EXP_BITS + MAN_BITS;

    // Pipeline state
    logic                  valid_a, valid_b;
    logic [W-1:0]          mant_a;
    logic signed [EW-1:0]  exp_a;
    logic                  sign_a, zero_a;
    logic [TAG_WIDTH-1:0]  tag_a;
    logic [LZW-1:0]        lzc_a;

    logic [AW-1:0]         abs_b;
    logic [1:0]            rs_b;
    logic                  sign_b, zero_b, ovf_b;
    logic [TAG_WIDTH-1:0]  tag_b;

    logic                  ready_a_c, ready_b_c;
    logic [LZW-1:0]        lzc_c;

    assign ready_b_c  = ~valid_b | out_ready_i;
    assign ready_a_c  = ~valid_a | ready_b_c;
    assign in_ready_o = ready_a_c;

    // Highest set bit wins; all-zero input yields W.
    always_comb begin
        lzc_c = LZW'(W);
        for (int i = 0; i < W; i++) begin
            if (mant_i[i]) lzc_c = LZW'(W - 1 - i);
        end
    end

    logic signed [EW-1:0]  shamt_c, nexp_c, sh_c, fexp_c;
    logic [EW-1:0]         lsh_c, rsh_c;
    logic                  normal_c, ovf_c, out_sticky_c;
    logic [2*W-1:0]        wide_c;
    logic [W-1:0]          shifted_c;
    logic [AW-1:0]         abs_c;
    logic [1:0]            rs_c;
    logic                  unused_bits;

    always_comb begin
        shamt_c      = $signed(EW'(lzc_a)) - $signed(EW'(1));
        nexp_c       = exp_a - shamt_c;
        normal_c     = (nexp_c >= $signed(EW'(1)));
        sh_c         = normal_c ? shamt_c : (exp_a - $signed(EW'(1)));
        fexp_c       = normal_c ? nexp_c : '0;
        ovf_c        = normal_c && (nexp_c >= $signed(EW'((1 << EXP_BITS) - 1)));
        lsh_c        = EW'(sh_c);
        rsh_c        = EW'(-sh_c);
        wide_c       = '0;
        shifted_c    = '0;
        out_sticky_c = 1'b0;
        if (!sh_c[EW-1]) begin
            shifted_c = mant_a << lsh_c;
        end else if (rsh_c >= EW'(W)) begin
            // Shift saturates: the whole magnitude lands in sticky.
            out_sticky_c = |mant_a;
        end else begin
            wide_c       = {mant_a, W'(0)} >> rsh_c;
            shifted_c    = wide_c[2*W-1:W];
            out_sticky_c = |wide_c[W-1:0];
        end

        if (zero_a) begin
            abs_c = '0;
            rs_c  = 2'b00;
        end else if (ovf_c) begin
            abs_c = {{EXP_BITS{1'b1}}, MAN_BITS'(0)};
            rs_c  = 2'b00;
        end else begin
            abs_c = {fexp_c[EXP_BITS-1:0], shifted_c[W-3 -: MAN_BITS]};
            rs_c  = {shifted_c[W-3-MAN_BITS],
                     (|shifted_c[W-4-MAN_BITS:0]) | out_sticky_c};
        end
    end

    assign unused_bits = ^{fexp_c[EW-1:EXP_BITS], shifted_c[W-1:W-2]};

    // Valid flags: reset and flush win over any load.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            valid_a <= 1'b0;
            valid_b <= 1'b0;
        end else begin
            if (ready_a_c) valid_a <= in_valid_i;
            if (ready_b_c) valid_b <= valid_a;
        end
    end

    always_ff @(posedge clk_i) begin
        if (in_valid_i && ready_a_c) begin
            mant_a <= mant_i;
            exp_a  <= exp_i;
            sign_a <= sign_i;
            tag_a  <= tag_i;
            lzc_a  <= lzc_c;
            zero_a <= ~|mant_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (valid_a && ready_b_c) begin
            abs_b  <= abs_c;
            rs_b   <= rs_c;
            sign_b <= sign_a;
            tag_b  <= tag_a;
            zero_b <= zero_a;
            ovf_b  <= ovf_c && !zero_a;
        end
    end

    // Data registers are unreset; gating with valid keeps idle outputs at zero.
    assign out_valid_o    = valid_b;
    assign abs_value_o    = valid_b ? abs_b  : '0;
    assign round_sticky_o = valid_b ? rs_b   : '0;
    assign sign_o         = valid_b ? sign_b : 1'b0;
    assign tag_o          = valid_b ? tag_b  : '0;
    assign zero_o         = valid_b ? zero_b : 1'b0;
    assign overflow_o     = valid_b ? ovf_b  : 1'b0;

endmodule

// File: tb/tb_fpnew_normalize_pipe.sv
// Directed bench for fpnew_normalize_pipe with hand-computed expectations.
module tb_fpnew_normalize_pipe;

    localparam int unsigned EXP_BITS = 8;
    localparam int unsigned MAN_BITS = 23;
    localparam int unsigned W        = 50;
    localparam int unsigned TW       = 4;

    logic                         clk = 1'b0;
    logic                         rst, flush, in_valid, in_ready;
    logic [W-1:0]                 mant;
    logic [EXP_BITS+1:0]          expv;
    logic                         sign;
    logic [TW-1:0]                tag;
    logic                         out_valid, out_ready;
    logic [EXP_BITS+MAN_BITS-1:0] abs_value;
    logic [1:0]                   rs;
    logic                         sign_out, zero, ovf;
    logic [TW-1:0]                tag_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fpnew_normalize_pipe #(
        .EXP_BITS(EXP_BITS), .MAN_BITS(MAN_BITS), .IN_WIDTH(W), .TAG_WIDTH(TW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .mant_i(mant), .exp_i(expv), .sign_i(sign), .tag_i(tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .abs_value_o(abs_value), .round_sticky_o(rs),
        .sign_o(sign_out), .tag_o(tag_out),
        .zero_o(zero), .overflow_o(ovf)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] req);
        tests++;
        assert (obs === req) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", name, obs, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One op through an empty pipe with the output always ready.
    task automatic run_op(input string name, input logic [W-1:0] m,
                          input logic [EXP_BITS+1:0] e, input logic [TW-1:0] t,
                          input logic [30:0] eabs, input logic [1:0] ers,
                          input logic ez, input logic eo);
        mant = m; expv = e; tag = t; sign = t[0];
        in_valid = 1'b1; out_ready = 1'b1;
        check({name, " in_ready"}, 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        check({name, " valid_c1"}, 64'(out_valid), 64'(0));
        step();
        check({name, " valid_c2"}, 64'(out_valid), 64'(1));
        check({name, " abs"},      64'(abs_value), 64'(eabs));
        check({name, " rs"},       64'(rs), 64'(ers));
        check({name, " zero"},     64'(zero), 64'(ez));
        check({name, " ovf"},      64'(ovf), 64'(eo));
        check({name, " tag"},      64'(tag_out), 64'(t));
        check({name, " sign"},     64'(sign_out), 64'(t[0]));
        step();
        check({name, " valid_c3"}, 64'(out_valid), 64'(0));
    endtask

    // Two ops parked in the pipe with the output stalled.
    task automatic fill_two();
        out_ready = 1'b0;
        mant = W'(1) << 48; expv = 10'd127; tag = 4'd5; sign = 1'b1;
        in_valid = 1'b1;
        step();
        tag = 4'd6;
        step();
        check("fill valid", 64'(out_valid), 64'(1));
        check("fill in_ready", 64'(in_ready), 64'(0));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        mant = '0; expv = '0; sign = 1'b0; tag = '0;
        step();
        step();
        rst = 1'b0;
        check("rst valid", 64'(out_valid), 64'(0));
        check("rst abs", 64'(abs_value), 64'(0));
        check("rst rs", 64'(rs), 64'(0));
        check("rst flags", 64'({zero, ovf, sign_out, tag_out}), 64'(0));
        check("rst in_ready", 64'(in_ready), 64'(1));

        run_op("one",     W'(1) << 48,               10'd127,   4'd1, 31'h3F800000, 2'b00, 1'b0, 1'b0);
        run_op("carry",   (W'(1) << 49) | W'(1),     10'd127,   4'd2, 31'h40000000, 2'b01, 1'b0, 1'b0);
        run_op("lz9",     W'(1) << 40,               10'd127,   4'd3, 31'h3B800000, 2'b00, 1'b0, 1'b0);
        run_op("rs11",    (W'(1) << 48) | (W'(1) << 24) | W'(1),
                                                     10'd127,   4'd4, 31'h3F800000, 2'b11, 1'b0, 1'b0);
        run_op("sub_m1",  W'(1) << 48,               -10'sd1,   4'd5, 31'h00200000, 2'b00, 1'b0, 1'b0);
        run_op("sub_m60", W'(1) << 48,               -10'sd60,  4'd6, 31'h00000000, 2'b01, 1'b0, 1'b0);
        run_op("ovf",     W'(1) << 48,               10'd255,   4'd7, 31'h7F800000, 2'b00, 1'b0, 1'b1);
        run_op("zero",    W'(0),                     10'd127,   4'd8, 31'h00000000, 2'b00, 1'b1, 1'b0);

        // Backpressure: three ops offered while the output is stalled.
        out_ready = 1'b0;
        mant = W'(1) << 48; expv = 10'd127; tag = 4'd9; sign = 1'b1; in_valid = 1'b1;
        step();
        check("bp in_ready1", 64'(in_ready), 64'(1));
        expv = 10'd128; tag = 4'd10; sign = 1'b0;
        step();
        check("bp in_ready2", 64'(in_ready), 64'(0));
        check("bp valid", 64'(out_valid), 64'(1));
        check("bp abs0", 64'(abs_value), 64'(32'h3F800000));
        check("bp tag0", 64'(tag_out), 64'(9));
        expv = 10'd129; tag = 4'd11; sign = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("bp hold abs", 64'(abs_value), 64'(32'h3F800000));
            check("bp hold tag", 64'(tag_out), 64'(9));
            check("bp hold in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        check("bp d1 valid", 64'(out_valid), 64'(1));
        check("bp d1 abs", 64'(abs_value), 64'(32'h40000000));
        check("bp d1 tag", 64'(tag_out), 64'(10));
        step();
        check("bp d2 valid", 64'(out_valid), 64'(1));
        check("bp d2 abs", 64'(abs_value), 64'(32'h40800000));
        check("bp d2 tag", 64'(tag_out), 64'(11));
        step();
        check("bp d3 valid", 64'(out_valid), 64'(0));

        // Flush with two ops in flight and a new op offered the same cycle.
        fill_two();
        flush = 1'b1; tag = 4'd7;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("flush valid", 64'(out_valid), 64'(0));
        check("flush abs", 64'(abs_value), 64'(0));
        check("flush in_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush no stale", 64'(out_valid), 64'(0));
        end

        // Reset with two ops in flight.
        fill_two();
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("midrst valid", 64'(out_valid), 64'(0));
        check("midrst tag", 64'(tag_out), 64'(0));
        check("midrst in_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 3; i++) begin
            step();
            check("midrst no stale", 64'(out_valid), 64'(0));
        end

        run_op("after", W'(1) << 48, 10'd127, 4'd12, 31'h3F800000, 2'b00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
